// File: rtl/cu.sv
// -----------------------------------------------------------------------------
// cu -- main control unit of the 32-bit RISC datapath
//
// Decodes the 4-bit instruction opcode into datapath control signals.
// Every output is registered; outputs reflect the opcode sampled at the
// previous rising edge of clk. Unassigned opcodes decode as NOP.
//
// Ports
//   clk            in   system clock, rising-edge active
//   reset          in   synchronous, active-high; forces the NOP decode
//   Opcode[3:0]    in   instruction opcode field
//   RegDest        out  1 = write-back register from rd, 0 = from rt
//   Jump           out  unconditional jump
//   Branch         out  conditional branch (bne)
//   Sig_Mem_Read   out  data-memory read enable
//   Sig_Mem_to_Reg out  1 = write-back from memory, 0 = from ALU
//   Sig_Mem_Write  out  data-memory write enable
//   ALUSrc         out  1 = ALU operand B is sign-extended immediate
//   Sig_Reg_Write  out  register-file write enable
//   ALUOp[2:0]     out  000 AND, 001 OR, 010 ADD, 011 NOT, 110 SUB, 111 PASS-B
// -----------------------------------------------------------------------------
module cu (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Opcode,
    output logic       RegDest,
    output logic       Jump,
    output logic       Branch,
    output logic       Sig_Mem_Read,
    output logic       Sig_Mem_to_Reg,
    output logic       Sig_Mem_Write,
    output logic       ALUSrc,
    output logic       Sig_Reg_Write,
    output logic [2:0] ALUOp
);

    localparam logic [3:0] opAnd = 4'b0000;
    localparam logic [3:0] opOr  = 4'b0001;
    localparam logic [3:0] opAdd = 4'b0010;
    localparam logic [3:0] opNot = 4'b0011;
    localparam logic [3:0] opSub = 4'b0110;
    localparam logic [3:0] opLdi = 4'b0111;
    localparam logic [3:0] opLw  = 4'b1000;
    localparam logic [3:0] opSw  = 4'b1010;
    localparam logic [3:0] opBne = 4'b1110;
    localparam logic [3:0] opJmp = 4'b1111;

    localparam logic [2:0] aluAnd  = 3'b000;
    localparam logic [2:0] aluOr   = 3'b001;
    localparam logic [2:0] aluAdd  = 3'b010;
    localparam logic [2:0] aluNot  = 3'b011;
    localparam logic [2:0] aluSub  = 3'b110;
    localparam logic [2:0] aluPass = 3'b111;

    // Control word layout:
    // {RegDest, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp[2:0]}
    localparam logic [10:0] ctrlNop = 11'b0;

    // ---- stage p0: combinational opcode decode ----
    logic [10:0] ctrlP0;

    always_comb begin
        ctrlP0 = ctrlNop;
        unique case (Opcode)
            opAnd:   ctrlP0 = {8'b1000_0001, aluAnd};
            opOr:    ctrlP0 = {8'b1000_0001, aluOr};
            opAdd:   ctrlP0 = {8'b1000_0001, aluAdd};
            opNot:   ctrlP0 = {8'b1000_0001, aluNot};
            opSub:   ctrlP0 = {8'b1000_0001, aluSub};
            // ALU passes the immediate straight through to write-back.
            opLdi:   ctrlP0 = {8'b0000_0011, aluPass};
            // Address = rs + imm, so the ALU adds.
            opLw:    ctrlP0 = {8'b0001_1011, aluAdd};
            opSw:    ctrlP0 = {8'b0000_0110, aluAdd};
            // Compare by subtraction; the taken decision lives in PC logic.
            opBne:   ctrlP0 = {8'b0010_0000, aluSub};
            opJmp:   ctrlP0 = {8'b0100_0000, aluAnd};
            default: ctrlP0 = ctrlNop;
        endcase
    end

    // ---- stage p1: output register bank ----
    logic [10:0] ctrlP1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlP1 <= ctrlNop;
        end else begin
            ctrlP1 <= ctrlP0;
        end
    end

    assign RegDest        = ctrlP1[10];
    assign Jump           = ctrlP1[9];
    assign Branch         = ctrlP1[8];
    assign Sig_Mem_Read   = ctrlP1[7];
    assign Sig_Mem_to_Reg = ctrlP1[6];
    assign Sig_Mem_Write  = ctrlP1[5];
    assign ALUSrc         = ctrlP1[4];
    assign Sig_Reg_Write  = ctrlP1[3];
    assign ALUOp          = ctrlP1[2:0];

endmodule

// File: tb/tb_cu.sv
// -----------------------------------------------------------------------------
// tb_cu -- directed-vector bench for the control unit cu
//
// Each vector drives reset/Opcode, waits one rising edge, then compares the
// packed control word
//   {RegDest, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp}
// against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_cu;

    logic       clk;
    logic       reset;
    logic [3:0] Opcode;
    logic       RegDest;
    logic       Jump;
    logic       Branch;
    logic       Sig_Mem_Read;
    logic       Sig_Mem_to_Reg;
    logic       Sig_Mem_Write;
    logic       ALUSrc;
    logic       Sig_Reg_Write;
    logic [2:0] ALUOp;

    int vecCount;
    int missCount;

    cu dut (
        .clk            (clk),
        .reset          (reset),
        .Opcode         (Opcode),
        .RegDest        (RegDest),
        .Jump           (Jump),
        .Branch         (Branch),
        .Sig_Mem_Read   (Sig_Mem_Read),
        .Sig_Mem_to_Reg (Sig_Mem_to_Reg),
        .Sig_Mem_Write  (Sig_Mem_Write),
        .ALUSrc         (ALUSrc),
        .Sig_Reg_Write  (Sig_Reg_Write),
        .ALUOp          (ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ctrlWord();
        return {RegDest, Jump, Branch, Sig_Mem_Read, Sig_Mem_to_Reg,
                Sig_Mem_Write, ALUSrc, Sig_Reg_Write, ALUOp};
    endfunction

    task automatic checkVec(input string tag, input logic [10:0] observed,
                            input logic [10:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit after it.
    task automatic applyVec(input string tag, input logic rst, input logic [3:0] op,
                            input logic [10:0] expected);
        reset  = rst;
        Opcode = op;
        @(posedge clk);
        #1;
        checkVec(tag, ctrlWord(), expected);
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        reset     = 1'b1;
        Opcode    = 4'b0010;

        // Reset held for two edges with add on the bus.
        applyVec("reset0", 1'b1, 4'b0010, 11'b000_00000_000);
        applyVec("reset1", 1'b1, 4'b0010, 11'b000_00000_000);
        applyVec("addAfterReset", 1'b0, 4'b0010, 11'b100_00001_010);

        // R-type sweep, back to back.
        applyVec("and", 1'b0, 4'b0000, 11'b100_00001_000);
        applyVec("or",  1'b0, 4'b0001, 11'b100_00001_001);
        applyVec("add", 1'b0, 4'b0010, 11'b100_00001_010);
        applyVec("not", 1'b0, 4'b0011, 11'b100_00001_011);
        applyVec("sub", 1'b0, 4'b0110, 11'b100_00001_110);

        // Immediate / memory.
        applyVec("ldi", 1'b0, 4'b0111, 11'b000_00011_111);
        applyVec("lw",  1'b0, 4'b1000, 11'b000_11011_010);
        applyVec("sw",  1'b0, 4'b1010, 11'b000_00110_010);

        // Control flow.
        applyVec("bne", 1'b0, 4'b1110, 11'b001_00000_110);
        applyVec("jmp", 1'b0, 4'b1111, 11'b010_00000_000);

        // Unassigned opcodes decode as NOP.
        applyVec("nop0100", 1'b0, 4'b0100, 11'b000_00000_000);
        applyVec("nop0101", 1'b0, 4'b0101, 11'b000_00000_000);
        applyVec("nop1001", 1'b0, 4'b1001, 11'b000_00000_000);
        applyVec("nop1011", 1'b0, 4'b1011, 11'b000_00000_000);
        applyVec("nop1100", 1'b0, 4'b1100, 11'b000_00000_000);
        applyVec("nop1101", 1'b0, 4'b1101, 11'b000_00000_000);

        // Output holds between edges even if Opcode changes mid-cycle.
        applyVec("jmpAgain", 1'b0, 4'b1111, 11'b010_00000_000);
        Opcode = 4'b0010;
        #3;
        checkVec("holdMidCycle", ctrlWord(), 11'b010_00000_000);

        // Mid-stream reset: lw decoded, reset clears it, lw returns after release.
        applyVec("lwPreReset",  1'b0, 4'b1000, 11'b000_11011_010);
        applyVec("midReset",    1'b1, 4'b1000, 11'b000_00000_000);
        applyVec("lwPostReset", 1'b0, 4'b1000, 11'b000_11011_010);

        // Reset dominates a simultaneous opcode change.
        applyVec("resetVsJmp", 1'b1, 4'b1111, 11'b000_00000_000);
        applyVec("swAfter",    1'b0, 4'b1010, 11'b000_00110_010);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
